// File: rtl/count_sequence_monitor_pkg.sv
// Shared constants and state encoding for the counter sequence monitor.
package count_sequence_monitor_pkg;

  localparam logic [2:0] C_ONE   = 3'b001;
  localparam logic [2:0] C_SEVEN = 3'b111;
  localparam logic [2:0] C_THREE = 3'b011;
  localparam logic [2:0] C_FIVE  = 3'b101;

  localparam logic MODE_A = 1'b0;
  localparam logic MODE_B = 1'b1;

  typedef enum logic [1:0] {
    StUnlocked = 2'b00,
    StTrack    = 2'b01,
    StFault    = 2'b10
  } mon_state_e;

endpackage

// File: rtl/seq_successor.sv
// Legal successor of a counter value for either mode; even values have no
// successor and map to 1.
module seq_successor
  import count_sequence_monitor_pkg::*;
(
  input  logic [2:0] prev_count,
  input  logic       mode,
  output logic [2:0] next_count
);

  always_comb begin
    next_count = C_ONE;
    if (mode == MODE_A) begin
      case (prev_count)
        C_ONE:   next_count = C_SEVEN;
        C_SEVEN: next_count = C_THREE;
        C_THREE: next_count = C_FIVE;
        default: next_count = C_ONE;
      endcase
    end else if (mode == MODE_B) begin
      case (prev_count)
        C_ONE:   next_count = C_FIVE;
        C_FIVE:  next_count = C_THREE;
        C_THREE: next_count = C_SEVEN;
        default: next_count = C_ONE;
      endcase
    end
  end

endmodule

// File: rtl/count_sequence_monitor.sv
// Observes the 3-bit Moore counter, predicts each value from the previous
// cycle's count and controls, and flags deviations and completed laps.
module count_sequence_monitor
  import count_sequence_monitor_pkg::*;
#(
  parameter int unsigned LAP_W = 8,
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       count,
  input  logic             enable,
  input  logic             mode,
  input  logic             ctr_rst,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic             fault,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [LAP_W-1:0] LapOne = LAP_W'(1);
  localparam logic [ERR_W-1:0] ErrOne = ERR_W'(1);

  mon_state_e state_q, state_d;

  logic [2:0]       prev_count_q;
  logic             prev_enable_q;
  logic             prev_mode_q;
  logic             prev_ctr_rst_q;
  logic             err_q;
  logic [LAP_W-1:0] lap_cnt_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [2:0] succ_count;
  logic [2:0] expected;
  logic       mismatch;
  logic       checking;
  logic       lap_hit;

  seq_successor u_seq_successor (
    .prev_count (prev_count_q),
    .mode       (prev_mode_q),
    .next_count (succ_count)
  );

  always_comb begin
    if (prev_ctr_rst_q) begin
      expected = C_ONE;
    end else if (prev_enable_q) begin
      expected = succ_count;
    end else begin
      expected = prev_count_q;
    end
  end

  // Even values never appear in a legal sequence, whatever was predicted.
  assign mismatch = (count != expected) || !count[0];
  assign checking = (state_q != StUnlocked);
  assign lap_hit  = checking && (count == C_ONE) && (prev_count_q != C_ONE) &&
                    prev_enable_q && !prev_ctr_rst_q && !mismatch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_count_q   <= C_ONE;
      prev_enable_q  <= 1'b0;
      prev_mode_q    <= MODE_A;
      prev_ctr_rst_q <= 1'b0;
    end else begin
      prev_count_q   <= count;
      prev_enable_q  <= enable;
      prev_mode_q    <= mode;
      prev_ctr_rst_q <= ctr_rst;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StUnlocked;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StUnlocked;
    end else begin
      unique case (state_q)
        StUnlocked: if (count[0]) state_d = StTrack;
        StTrack:    if (mismatch) state_d = StFault;
        StFault:    state_d = StFault;
        default:    state_d = StUnlocked;
      endcase
    end
  end

  always_comb begin
    locked = 1'b0;
    fault  = 1'b0;
    unique case (state_q)
      StUnlocked: ;
      StTrack:    locked = 1'b1;
      StFault: begin
        locked = 1'b1;
        fault  = 1'b1;
      end
      default: ;
    endcase
  end

  // clear outranks a same-cycle mismatch or lap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q     <= 1'b0;
      lap_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (clear) begin
      err_q     <= 1'b0;
      lap_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_q <= checking && mismatch;
      if (checking && mismatch && (err_cnt_q != {ERR_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + ErrOne;
      end
      if (lap_hit && (lap_cnt_q != {LAP_W{1'b1}})) begin
        lap_cnt_q <= lap_cnt_q + LapOne;
      end
    end
  end

  assign err     = err_q;
  assign lap_cnt = lap_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Randomized and directed bench for count_sequence_monitor against a
// ring-lookup reference model of the counter sequences.
module tb_count_sequence_monitor;

  localparam int unsigned LAP_W = 8;
  localparam int unsigned ERR_W = 4;
  localparam int LapMax = (1 << LAP_W) - 1;
  localparam int ErrMax = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       count;
  logic             enable;
  logic             mode;
  logic             ctr_rst;
  logic             clear;
  logic             locked;
  logic             err;
  logic             fault;
  logic [LAP_W-1:0] lap_cnt;
  logic [ERR_W-1:0] err_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: last sampled inputs plus predicted outputs.
  int p_cnt, p_en, p_mode, p_rst;
  int m_locked, m_err, m_fault, m_lap, m_errc;

  count_sequence_monitor #(
    .LAP_W (LAP_W),
    .ERR_W (ERR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .enable  (enable),
    .mode    (mode),
    .ctr_rst (ctr_rst),
    .clear   (clear),
    .locked  (locked),
    .err     (err),
    .fault   (fault),
    .lap_cnt (lap_cnt),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int succ(int p, int m);
    int ring [2][4] = '{'{1, 7, 3, 5}, '{1, 5, 3, 7}};
    for (int i = 0; i < 4; i++) begin
      if (ring[m][i] == p) return ring[m][(i + 1) % 4];
    end
    return 1;
  endfunction

  function automatic int expect_now();
    if (p_rst != 0) return 1;
    if (p_en != 0) return succ(p_cnt, p_mode);
    return p_cnt;
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("locked", int'(locked), m_locked);
    check_val("err", int'(err), m_err);
    check_val("fault", int'(fault), m_fault);
    check_val("lap_cnt", int'(lap_cnt), m_lap);
    check_val("err_cnt", int'(err_cnt), m_errc);
  endtask

  task automatic model_reset();
    p_cnt = 1; p_en = 0; p_mode = 0; p_rst = 0;
    m_locked = 0; m_err = 0; m_fault = 0; m_lap = 0; m_errc = 0;
  endtask

  task automatic model_edge();
    int  e;
    bit  mm;
    bit  chk;
    e   = expect_now();
    mm  = (int'(count) != e) || (int'(count) % 2 == 0);
    chk = (m_locked != 0);
    if (clear) begin
      m_locked = 0; m_err = 0; m_fault = 0; m_lap = 0; m_errc = 0;
    end else begin
      m_err = (chk && mm) ? 1 : 0;
      if (chk && mm) begin
        m_fault = 1;
        if (m_errc < ErrMax) m_errc++;
      end
      if (chk && int'(count) == 1 && p_cnt != 1 && p_en != 0 && p_rst == 0 && !mm &&
          m_lap < LapMax) m_lap++;
      if (!chk && (int'(count) % 2 == 1)) m_locked = 1;
    end
    p_cnt = int'(count); p_en = int'(enable); p_mode = int'(mode); p_rst = int'(ctr_rst);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input int c, input bit e, input bit m, input bit r, input bit cl);
    count = 3'(c); enable = e; mode = m; ctr_rst = r; clear = cl;
  endtask

  task automatic run_good(input int n, input bit e, input bit m);
    repeat (n) begin
      drive(expect_now(), e, m, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic inject(input int v, input bit e, input bit m);
    drive(v, e, m, 1'b0, 1'b0);
    tick();
  endtask

  task automatic advance_to(input int target, input bit m);
    int guard = 0;
    while (expect_now() != target && guard < 8) begin
      run_good(1, 1'b1, m);
      guard++;
    end
    check_val("advance_reached", expect_now(), target);
  endtask

  initial begin
    bit cur_mode;
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #3;
    check_outputs();
    #20 reset = 1'b1;

    // ctr_rst pulse, then clean mode-0 and mode-1 sequences.
    drive(1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    run_good(12, 1'b1, 1'b0);
    check_val("laps_mode0", int'(lap_cnt), 2);
    run_good(8, 1'b1, 1'b1);

    // Wrong successor in TRACK.
    advance_to(7, 1'b0);
    inject(3, 1'b1, 1'b0);
    run_good(3, 1'b1, 1'b0);

    // Holds, then an illegal even value.
    advance_to(3, 1'b0);
    run_good(5, 1'b0, 1'b0);
    run_good(2, 1'b1, 1'b0);
    inject(4, 1'b1, 1'b0);
    run_good(2, 1'b1, 1'b0);

    // Mode switch on the 7: legal return to 1, then the illegal 3.
    advance_to(7, 1'b0);
    run_good(1, 1'b1, 1'b1);
    run_good(2, 1'b1, 1'b0);
    advance_to(7, 1'b0);
    drive(7, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    inject(3, 1'b1, 1'b0);

    // Saturate err_cnt, then clear together with a mismatch, then relock.
    repeat (20) inject(2, 1'b1, 1'b0);
    drive(6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    run_good(6, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2 reset = 1'b1;

    // Randomized traffic with occasional corruption, ctr_rst and clear.
    cur_mode = 1'b0;
    repeat (800) begin
      int c;
      bit e, r, cl;
      if ($urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
      e  = ($urandom_range(0, 99) < 70);
      r  = ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : expect_now();
      drive(c, e, cur_mode, r, cl);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/count_sequence_monitor.md
Name: count_sequence_monitor

Overview:
- Downstream checker for the 3-bit Moore random counter.
- Watches the counter's `count` output plus the same `enable`, `mode` and `ctr_rst` signals that drive the counter.
- Predicts the exact value each cycle and flags any deviation. Also counts completed laps (wraps back to 1).
- Sits between the counter and the display/status logic; purely observational, never drives the counter.

Parameters:
- LAP_W, 8, width of the saturating lap counter.
- ERR_W, 4, width of the saturating mismatch counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- count  input  3  counter output under observation.
- enable  input  1  counter enable, as presented to the counter.
- mode  input  1  counter mode (0: 1-7-3-5, 1: 1-5-3-7).
- ctr_rst  input  1  counter's synchronous reset, as presented to the counter.
- clear  input  1  synchronous clear of fault, counters and lock.
- locked  output  1  monitor has a valid reference and is checking.
- err  output  1  one-cycle pulse per detected mismatch.
- fault  output  1  sticky; set on first mismatch, cleared only by clear or reset.
- lap_cnt  output  LAP_W  completed laps, saturating at all-ones.
- err_cnt  output  ERR_W  mismatches detected, saturating at all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=UNLOCKED.
  - prev_count=3'b001; prev_enable, prev_mode, prev_ctr_rst = 0.
  - All outputs 0.
- Every rising edge, the registers prev_count, prev_enable, prev_mode and prev_ctr_rst capture count, enable, mode and ctr_rst.
- Expected value for the current cycle:
  - if prev_ctr_rst, expected = 1;
  - else if prev_enable, expected = succ(prev_count, prev_mode);
  - else expected = prev_count.
- Successor function:
  - mode 0: 1→7, 7→3, 3→5, 5→1.
  - mode 1: 1→5, 5→3, 3→7, 7→1.
  - Even prev_count: no legal successor; expected = 1 (error is raised by the illegal-value rule).
- Mismatch condition: count != expected, or count is even (0, 2, 4, 6).
- States:
  - UNLOCKED:
    - locked=0; no checking.
    - Go to TRACK on the edge where count is odd.
  - TRACK:
    - locked=1.
    - On mismatch: err=1 and err_cnt+1 on the next edge; go to FAULT.
  - FAULT:
    - locked=1, fault=1.
    - Checking continues; each further mismatch pulses err and increments err_cnt.
    - Exit only via clear or reset.
- Latency: a mismatch in the count sampled at edge N shows as err=1 during cycle N+1, one cycle wide. Back-to-back mismatches give consecutive err pulses.
- Lap rule:
  - Counted in TRACK or FAULT when: count==1, prev_count!=1, prev_enable=1, prev_ctr_rst=0, and no mismatch.
  - lap_cnt increments by 1 and holds at 2^LAP_W-1.
  - A return to 1 via ctr_rst is not a lap.
- Holds: enable low keeps count constant. This is legal and produces no lap.
- Mode switch mid-sequence: the prediction uses the mode registered on the transition edge. Example: count=7, mode switched 0→1 with enable high gives expected 1, not 3.
- clear (synchronous, highest priority after reset):
  - Next state UNLOCKED.
  - fault, err, lap_cnt, err_cnt all set to 0.
  - If clear and a mismatch occur in the same cycle, clear wins: no err pulse, no count.
- err_cnt saturates at 2^ERR_W-1; fault stays 1.
- Reset asserted mid-operation forces the reset values immediately, independent of clk.

Decomposition:
- Shared package holds:
  - Count constants C_ONE=3'b001, C_SEVEN=3'b111, C_THREE=3'b011, C_FIVE=3'b101.
  - Monitor state encoding UNLOCKED, TRACK, FAULT (2 bits).
  - Mode constants MODE_A=0, MODE_B=1.
- One combinational sub-module, `seq_successor` (inputs prev_count, mode; output next_count), is natural. Later benches can reuse it as a reference model.

Test Plan:
- Reset release, ctr_rst=1 one cycle, then enable=1, mode=0 for 12 cycles, count driven 1,7,3,5,1,7,3,5,1,7,3,5 → locked=1 from cycle 2; err never asserts; lap_cnt=2.
- Same with mode=1 and count 1,5,3,7,1,… for 8 cycles → err=0; lap_cnt=1.
- In TRACK, drive count=3 where expected is 7 → err=1 for exactly one cycle on the next cycle; fault=1 stays set; err_cnt=1.
- enable=0 for 5 cycles with count held at 3, then enable=1, count=5 → no err, lap_cnt unchanged; driving count=4 at any point → err, err_cnt+1.
- Mode switch at count=7, enable=1: count=1 next → no err, lap_cnt+1; count=3 next instead → err.
- fault=1 with err_cnt=15 (ERR_W=4), then a further mismatch → err pulses, err_cnt stays 15. Then assert clear together with a mismatch → no err; fault, err_cnt and lap_cnt = 0; locked=0, then relock on the next odd count. Finally, async reset mid-sequence → all outputs 0 immediately.
